// File: rtl/isa_bus_sequencer.sv
// isa_bus_sequencer: ISA bus cycle engine (setup, strobe, iochrdy wait, hold, done).
// Optional wait watchdog enabled by defining ISA_SEQ_TIMEOUT_EN.
//
// Ports:
//   clk, control_reset      clock, synchronous active-high reset
//   start                   one-cycle request, honoured only when idle
//   control_in[1:0]         {memory, write} cycle type; bits 7:2 unused
//   address_in, data_in     address and write data latched on start
//   isa_iochrdy             card ready, low stretches the strobe
//   isa_sd_in               bus read data
//   isa_sa, isa_sd_out      bus address / write data
//   isa_sd_oe               write data driver enable
//   isa_*_n                 active-low command strobes
//   read_data               captured read data
//   done, busy, timeout     completion pulse, in-progress, sticky timeout
//
// All bus outputs are registered from the next-state decode so strobes
// never glitch and never overlap across a state change.

module isa_bus_sequencer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 6,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        control_reset,
  input  logic        start,
  input  logic [7:0]  control_in,
  input  logic [15:0] address_in,
  input  logic [15:0] data_in,
  input  logic        isa_iochrdy,
  input  logic [15:0] isa_sd_in,
  output logic [15:0] isa_sa,
  output logic [15:0] isa_sd_out,
  output logic        isa_sd_oe,
  output logic        isa_iow_n,
  output logic        isa_ior_n,
  output logic        isa_memw_n,
  output logic        isa_memr_n,
  output logic [15:0] read_data,
  output logic        done,
  output logic        busy,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [5:0] SETUP_LD  = 6'(SETUP_CYCLES - 1);
  localparam logic [5:0] STROBE_LD = 6'(STROBE_CYCLES - 1);
  localparam logic [5:0] HOLD_LD   = 6'(HOLD_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nxt;
  logic [1:0]  ctrl_q;
  logic [1:0]  ctrl_nxt;
  logic [15:0] addr_q;
  logic [15:0] addr_nxt;
  logic [15:0] data_q;
  logic [15:0] data_nxt;
  logic        accept;
  logic        capture;
  logic        expire;
  logic        drive_nxt;
  logic        strobe_nxt;
  logic        wr_nxt;

  logic unused_ctrl;
  assign unused_ctrl = ^control_in[7:2];

  assign accept   = (state == S_IDLE) && start;
  assign ctrl_nxt = accept ? control_in[1:0] : ctrl_q;
  assign addr_nxt = accept ? address_in : addr_q;
  assign data_nxt = accept ? data_in : data_q;

`ifdef ISA_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already spent
  assign expire = (state == S_WAIT) && !isa_iochrdy &&
                  (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (control_reset || state != S_WAIT)
      wait_cnt <= 8'd0;
    else
      wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (control_reset)
      timeout <= 1'b0;
    else if (accept)
      timeout <= 1'b0;
    else if (expire)
      timeout <= 1'b1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt == 6'd0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      S_STROBE: begin
        if (cnt != 6'd0) begin
          cnt_nxt = cnt - 6'd1;
        end else if (isa_iochrdy) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
          capture   = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (isa_iochrdy) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
          capture   = 1'b1;
        end else if (expire) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt == 6'd0)
          state_nxt = S_DONE;
        else
          cnt_nxt = cnt - 6'd1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign drive_nxt  = (state_nxt == S_SETUP)  ||
                      (state_nxt == S_STROBE) ||
                      (state_nxt == S_WAIT)   ||
                      (state_nxt == S_HOLD);
  assign strobe_nxt = (state_nxt == S_STROBE) ||
                      (state_nxt == S_WAIT);
  assign wr_nxt     = drive_nxt && ctrl_nxt[0];

  always_ff @(posedge clk) begin
    if (control_reset) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      ctrl_q     <= 2'b00;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      isa_sa     <= 16'h0000;
      isa_sd_out <= 16'h0000;
      isa_sd_oe  <= 1'b0;
      isa_ior_n  <= 1'b1;
      isa_iow_n  <= 1'b1;
      isa_memr_n <= 1'b1;
      isa_memw_n <= 1'b1;
      read_data  <= 16'h0000;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ctrl_q     <= ctrl_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      isa_sa     <= drive_nxt ? addr_nxt : 16'h0000;
      isa_sd_oe  <= wr_nxt;
      isa_sd_out <= wr_nxt ? data_nxt : 16'h0000;
      isa_ior_n  <= !(strobe_nxt && ctrl_nxt == 2'b00);
      isa_iow_n  <= !(strobe_nxt && ctrl_nxt == 2'b01);
      isa_memr_n <= !(strobe_nxt && ctrl_nxt == 2'b10);
      isa_memw_n <= !(strobe_nxt && ctrl_nxt == 2'b11);
      done       <= (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE);
      if (capture && !ctrl_q[0])
        read_data <= isa_sd_in;
      else if (expire && !ctrl_q[0])
        read_data <= 16'hFFFF;
    end
  end

endmodule

// File: tb/tb_isa_bus_sequencer.sv
// tb_isa_bus_sequencer: directed and random checks of isa_bus_sequencer
// against a timeline model of the bus cycle.

module tb_isa_bus_sequencer;

  localparam int S  = 2;
  localparam int T  = 6;
  localparam int H  = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        control_reset;
  logic        start;
  logic [7:0]  control_in;
  logic [15:0] address_in;
  logic [15:0] data_in;
  logic        isa_iochrdy;
  logic [15:0] isa_sd_in;
  logic [15:0] isa_sa;
  logic [15:0] isa_sd_out;
  logic        isa_sd_oe;
  logic        isa_iow_n;
  logic        isa_ior_n;
  logic        isa_memw_n;
  logic        isa_memr_n;
  logic [15:0] read_data;
  logic        done;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  isa_bus_sequencer #(
    .SETUP_CYCLES(S),
    .STROBE_CYCLES(T),
    .HOLD_CYCLES(H),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .control_reset(control_reset),
    .start(start),
    .control_in(control_in),
    .address_in(address_in),
    .data_in(data_in),
    .isa_iochrdy(isa_iochrdy),
    .isa_sd_in(isa_sd_in),
    .isa_sa(isa_sa),
    .isa_sd_out(isa_sd_out),
    .isa_sd_oe(isa_sd_oe),
    .isa_iow_n(isa_iow_n),
    .isa_ior_n(isa_ior_n),
    .isa_memw_n(isa_memw_n),
    .isa_memr_n(isa_memr_n),
    .read_data(read_data),
    .done(done),
    .busy(busy),
    .timeout(timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: a cycle is a timeline t = 1.. counted from the accept edge.
  // m_rel is the first hold cycle, known once ready (or timeout) arrives.
  bit          m_act  = 0;
  int          m_t    = 0;
  int          m_rel  = 0;
  logic [1:0]  m_ctrl = 2'b00;
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_rd   = 16'h0;
  bit          m_tmo  = 0;

  always @(posedge clk) begin
    if (control_reset) begin
      m_act = 0;
      m_rd  = 16'h0;
      m_tmo = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act  = 1;
        m_t    = 1;
        m_rel  = 0;
        m_ctrl = control_in[1:0];
        m_addr = address_in;
        m_data = data_in;
        m_tmo  = 0;
      end
    end else begin
      if (m_rel == 0 && m_t >= S + T) begin
        if (isa_iochrdy) begin
          m_rel = m_t + 1;
          if (!m_ctrl[0]) m_rd = isa_sd_in;
        end
`ifdef ISA_SEQ_TIMEOUT_EN
        else if (m_t - (S + T) == TO) begin
          m_rel = m_t + 1;
          if (!m_ctrl[0]) m_rd = 16'hFFFF;
          m_tmo = 1;
        end
`endif
      end
      if (m_rel != 0 && m_t == m_rel + H)
        m_act = 0;
      else
        m_t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit su, sb, hd, dn, drv, wr;
      su  = m_act && m_t <= S;
      sb  = m_act && m_t > S && m_rel == 0;
      hd  = m_act && m_rel != 0 && m_t < m_rel + H;
      dn  = m_act && m_rel != 0 && m_t == m_rel + H;
      drv = su || sb || hd;
      wr  = drv && m_ctrl[0];
      chk("busy", busy, m_act);
      chk("done", done, dn);
      chk("sa", isa_sa, drv ? m_addr : 16'h0);
      chk("sd_oe", isa_sd_oe, wr);
      chk("sd_out", isa_sd_out, wr ? m_data : 16'h0);
      chk("ior_n", isa_ior_n, !(sb && m_ctrl == 2'b00));
      chk("iow_n", isa_iow_n, !(sb && m_ctrl == 2'b01));
      chk("memr_n", isa_memr_n, !(sb && m_ctrl == 2'b10));
      chk("memw_n", isa_memw_n, !(sb && m_ctrl == 2'b11));
      chk("read_data", read_data, m_rd);
      chk("timeout", timeout, m_tmo);
    end
  end

  // iochrdy is held low from the last strobe cycle for wait_low cycles
  task automatic run_txn(input logic [7:0] ctrl,
                         input logic [15:0] addr,
                         input logic [15:0] data,
                         input logic [15:0] sd,
                         input int wait_low,
                         output int low_cnt,
                         output int oe_cnt,
                         output int done_cyc,
                         output logic [3:0] seen,
                         output logic [15:0] rd_at_done,
                         output logic tmo_at_done);
    @(negedge clk);
    control_in  = ctrl;
    address_in  = addr;
    data_in     = data;
    isa_sd_in   = sd;
    isa_iochrdy = 1'b1;
    start       = 1'b1;
    low_cnt     = 0;
    oe_cnt      = 0;
    done_cyc    = 0;
    seen        = 4'b0;
    rd_at_done  = 16'h0;
    tmo_at_done = 1'b0;
    for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      isa_iochrdy = !(c >= S + T && c < S + T + wait_low);
      seen |= {~isa_memw_n, ~isa_memr_n, ~isa_iow_n, ~isa_ior_n};
      if (!(isa_iow_n & isa_ior_n & isa_memw_n & isa_memr_n))
        low_cnt++;
      if (isa_sd_oe) oe_cnt++;
      if (done) begin
        done_cyc    = c;
        rd_at_done  = read_data;
        tmo_at_done = timeout;
      end
    end
    isa_iochrdy = 1'b1;
  endtask

  initial begin
    int lc, oc, dc, edges;
    logic [3:0] sn;
    logic [15:0] rd, sa_mid;
    logic tm, prev;

    control_reset = 1'b1;
    start         = 1'b0;
    control_in    = 8'h0;
    address_in    = 16'h0;
    data_in       = 16'h0;
    isa_iochrdy   = 1'b1;
    isa_sd_in     = 16'h0;
    repeat (2) @(negedge clk);
    control_reset = 1'b0;
    chk_en = 1;

    chk("rst_busy", busy, 1'b0);
    chk("rst_sa", isa_sa, 16'h0);
    chk("rst_ior", isa_ior_n, 1'b1);
    chk("rst_rd", read_data, 16'h0);

    run_txn(8'h01, 16'h0220, 16'h00A5, 16'h0, 0, lc, oc, dc, sn, rd, tm);
    chk("iow_low_cycles", lc, 6);
    chk("iow_which", sn, 4'b0010);
    chk("iow_oe_cycles", oc, 10);
    chk("iow_done_cyc", dc, 11);

    run_txn(8'h00, 16'h022A, 16'h5555, 16'h00AA, 0, lc, oc, dc, sn, rd, tm);
    chk("ior_low_cycles", lc, 6);
    chk("ior_which", sn, 4'b0001);
    chk("ior_oe_cycles", oc, 0);
    chk("ior_data", rd, 16'h00AA);
    chk("ior_done_cyc", dc, 11);

    run_txn(8'hFF, 16'hD000, 16'h1234, 16'h0, 4, lc, oc, dc, sn, rd, tm);
    chk("memw_low_cycles", lc, 10);
    chk("memw_which", sn, 4'b1000);
    chk("memw_done_cyc", dc, 15);
    chk("memw_timeout", tm, 1'b0);

    // start held during busy, then a second start once idle
    @(negedge clk);
    control_in = 8'h01;
    address_in = 16'h1111;
    start = 1'b1;
    edges = 0;
    prev = 1'b1;
    sa_mid = 16'h0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c < 8) begin
        start = 1'b1;
        address_in = 16'($urandom);
      end else if (c == 14) begin
        start = 1'b1;
        address_in = 16'h2222;
      end else begin
        start = 1'b0;
      end
      if (prev && !isa_iow_n) edges++;
      prev = isa_iow_n;
      if (c == 5) sa_mid = isa_sa;
    end
    chk("held_start_strobes", edges, 2);
    chk("held_start_addr", sa_mid, 16'h1111);

    // reset in the third strobe cycle
    @(negedge clk);
    control_in = 8'h01;
    address_in = 16'h0300;
    start = 1'b1;
    edges = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        chk("pre_rst_iow", isa_iow_n, 1'b0);
        control_reset = 1'b1;
      end else if (c == 6) begin
        chk("abort_iow", isa_iow_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        control_reset = 1'b0;
      end else if (c > 6 && done) begin
        edges++;
      end
    end
    chk("abort_no_done", edges, 0);

`ifdef ISA_SEQ_TIMEOUT_EN
    run_txn(8'h00, 16'h0400, 16'h0, 16'h1234, 1000, lc, oc, dc, sn, rd, tm);
    chk("tmo_flag", tm, 1'b1);
    chk("tmo_data", rd, 16'hFFFF);
    chk("tmo_done_cyc", dc, S + T + TO + H + 1);
    chk("tmo_low_cycles", lc, T + TO);
    run_txn(8'h00, 16'h0402, 16'h0, 16'h4321, 0, lc, oc, dc, sn, rd, tm);
    chk("tmo_cleared", tm, 1'b0);
    chk("tmo_next_data", rd, 16'h4321);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start         = ($urandom % 8) == 0;
      control_in    = 8'($urandom);
      address_in    = 16'($urandom);
      data_in       = 16'($urandom);
      isa_sd_in     = 16'($urandom);
      isa_iochrdy   = ($urandom % 4) != 0;
      control_reset = ($urandom % 200) == 0;
    end
    @(negedge clk);
    start = 1'b0;
    control_reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_bus_sequencer.md
ISA_BUS_SEQUENCER -- requirements
Module: isa_bus_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- SETUP_CYCLES, 2, address setup before strobe, range 1-15
- STROBE_CYCLES, 6, minimum strobe low width, range 1-63
- HOLD_CYCLES, 2, address/data hold after strobe, range 1-15
- TIMEOUT_CYCLES, 255, IOCHRDY wait limit, range 1-255
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge
- control_reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse from host side
- control_in  in  8  bit0 1=write/0=read, bit1 1=memory/0=I/O, bits7:2 ignored
- address_in  in  16  bus address from address register
- data_in  in  16  write data from data register
- isa_iochrdy  in  1  card ready; low stretches the strobe
- isa_sd_in  in  16  bus data sampled on reads
- isa_sa  out  16  bus address
- isa_sd_out  out  16  bus write data
- isa_sd_oe  out  1  data driver enable
- isa_iow_n, isa_ior_n, isa_memw_n, isa_memr_n  out  1 each  active-low strobes
- read_data  out  16  captured read data, fed back to the data register
- done  out  1  one-cycle completion pulse
- busy  out  1  cycle in progress
- timeout  out  1  sticky wait-timeout flag

Function
REQ-003 States SHALL be IDLE, SETUP, STROBE, WAIT, HOLD, DONE.
REQ-004 In IDLE with start=1, the block SHALL latch control_in, address_in and data_in, enter SETUP on the next edge, and hold busy=1 from that edge until it returns to IDLE.
REQ-005 A start pulse outside IDLE SHALL be ignored, with no queuing and no change to latched values.
REQ-006 isa_sa SHALL drive the latched address in SETUP, STROBE, WAIT and HOLD, and 0x0000 in IDLE and DONE.
REQ-007 isa_sd_oe SHALL be 1 with isa_sd_out equal to the latched data in SETUP, STROBE, WAIT and HOLD for writes only; otherwise isa_sd_oe=0 and isa_sd_out=0x0000.
REQ-008 SETUP SHALL last exactly SETUP_CYCLES cycles with all strobes high.
REQ-009 In STROBE and WAIT exactly one strobe SHALL be low, selected by {bit1,bit0}: 00 ior_n, 01 iow_n, 10 memr_n, 11 memw_n.
REQ-010 STROBE SHALL last STROBE_CYCLES cycles; on its last cycle, isa_iochrdy=0 SHALL move to WAIT and isa_iochrdy=1 SHALL move to HOLD.
REQ-011 WAIT SHALL move to HOLD on the first cycle with isa_iochrdy=1.
REQ-012 For reads, read_data SHALL capture isa_sd_in on the cycle that leaves STROBE or WAIT for HOLD, and SHALL otherwise hold its value.
REQ-013 HOLD SHALL last exactly HOLD_CYCLES cycles with strobes high.
REQ-014 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-015 With iochrdy always high, a cycle SHALL take SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles from the edge after start to the done pulse inclusive.
REQ-016 At most one strobe SHALL be low in any cycle, including across state transitions.

Reset
REQ-017 On control_reset=1 at a clock edge, the state SHALL become IDLE and the outputs SHALL become: strobes 1; isa_sa, isa_sd_out, read_data 0x0000; isa_sd_oe, done, busy, timeout 0.
REQ-018 Reset mid-cycle SHALL abort with strobes high on the next edge and no done pulse.
REQ-019 control_reset SHALL take priority over start in the same cycle.

Configuration
REQ-020 With ISA_SEQ_TIMEOUT_EN defined, a wait counter SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES it SHALL force HOLD, set read_data=0xFFFF for reads, and set timeout=1.
REQ-021 With ISA_SEQ_TIMEOUT_EN defined, timeout SHALL stay set until control_reset or the next accepted start.
REQ-022 Without ISA_SEQ_TIMEOUT_EN, WAIT SHALL be unbounded, no counter logic SHALL exist, and timeout SHALL be tied to 0.

Verification
REQ-023 I/O write, defaults, ctrl=0x01, addr=0x0220, data=0x00A5, iochrdy=1 -> iow_n low for exactly 6 cycles, sd_oe high for 10 cycles, done on cycle 11.
REQ-024 I/O read, ctrl=0x00, addr=0x022A, isa_sd_in=0x00AA -> ior_n low for 6 cycles, read_data=0x00AA at done, sd_oe never 1.
REQ-025 Memory write, ctrl=0x03, iochrdy low for 4 cycles after the strobe minimum -> memw_n low for 10 cycles, done on cycle 15.
REQ-026 start held high during busy, then a second start in IDLE -> only one strobe per accepted start, and latched addr unchanged mid-cycle.
REQ-027 control_reset asserted on the 3rd STROBE cycle -> all strobes high and busy=0 next edge, no done pulse.
REQ-028 ISA_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, iochrdy stuck low on a read -> timeout=1, read_data=0xFFFF, done asserted; the next start clears timeout.
